eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameter pIPG_CYCLES, default 48, Clk cycles of inter-packet gap (96 bit times at 2 bits/clk).
REQ-002 SHALL have parameter pTIMEOUT, default 4096, maximum Clk cycles a grant may stay active without Tx_Done.
REQ-003 SHALL have port Clk  input  1  single clock, rising edge, RMII reference clock domain.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Req  input  2  per-requester frame-ready level, bit i = requester i.
REQ-006 SHALL have port Gnt  output  2  one-hot grant, held for the whole frame.
REQ-007 SHALL have port Tx_Sel  output  1  transmit-path mux select, index of granted requester.
REQ-008 SHALL have port Tx_Start  output  1  one-cycle pulse starting the transmit engine.
REQ-009 SHALL have port Tx_Done  input  1  one-cycle pulse from transmit engine after last FCS dibit.
REQ-010 SHALL have port Tx_Abort  output  1  one-cycle pulse on watchdog expiry.
REQ-011 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ACTIVE, IPG; all outputs registered.
REQ-013 IDLE: if Req != 0 at a rising edge, SHALL enter ACTIVE with Gnt one-hot, Tx_Sel, Tx_Start=1 all valid the following cycle (latency 1).
REQ-014 Tx_Start SHALL be high exactly one cycle per grant, the first ACTIVE cycle.
REQ-015 Arbitration SHALL be round-robin: single requester wins; both requesting, the requester != rLast wins; rLast updated at grant.
REQ-016 ACTIVE: Gnt and Tx_Sel SHALL stay constant; deassertion of Req SHALL be ignored until frame end.
REQ-017 ACTIVE: 16-bit watchdog SHALL clear on entry, increment each cycle.
REQ-018 ACTIVE with Tx_Done=1: SHALL enter IPG; Gnt=0 the next cycle.
REQ-019 ACTIVE with watchdog == pTIMEOUT-1 and Tx_Done=0: SHALL pulse Tx_Abort one cycle, clear Gnt, enter IPG.
REQ-020 Tx_Done and watchdog expiry in the same cycle: Tx_Done SHALL win, no Tx_Abort.
REQ-021 IPG: gap counter SHALL clear on entry, count 0..pIPG_CYCLES-1, enter IDLE when count == pIPG_CYCLES-1.
REQ-022 Gnt SHALL therefore be 0 for at least pIPG_CYCLES+1 cycles between consecutive grants.
REQ-023 Tx_Done in IDLE or IPG SHALL be ignored; Req changes in IPG SHALL not shorten the gap.
REQ-024 Gnt SHALL never have both bits set; Tx_Sel SHALL equal Gnt[1] whenever Gnt != 0.
REQ-025 Illegal state encoding SHALL return to IDLE next cycle with all outputs cleared.

Reset
REQ-026 Rst_n low SHALL asynchronously force IDLE, Gnt=0, Tx_Sel=0, Tx_Start=0, Tx_Abort=0, Busy=0, counters=0, rLast=1.
REQ-027 Reset mid-ACTIVE or mid-IPG SHALL abandon the frame/gap with no Tx_Abort; first request after release granted per REQ-013.
REQ-028 Reset deassertion SHALL be synchronised so the FSM leaves reset on a clean Clk edge.

Verification
REQ-029 After reset, Req=2'b11 -> next cycle Gnt=2'b01, Tx_Sel=0, Tx_Start=1 one cycle, Busy=1.
REQ-030 Hold Req=2'b11, Tx_Done after 200 cycles -> Gnt=0 for exactly 49 cycles, then Gnt=2'b10, Tx_Sel=1; next frame back to 2'b01.
REQ-031 Req=2'b01 only, repeated frames -> requester 0 granted every time, 49-cycle gaps.
REQ-032 Grant, no Tx_Done -> Tx_Abort pulse on the cycle after watchdog reaches 4095, Gnt=0, 48-cycle IPG.
REQ-033 Tx_Done coincident with watchdog 4095 -> no Tx_Abort, normal IPG.
REQ-034 Rst_n low in mid-ACTIVE, asynchronously between edges -> Gnt, Busy drop immediately; Tx_Abort stays 0.

Source files
------------

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arb
// Brief    : Two-requester round-robin RMII transmit arbiter with IPG and watchdog.
// Revision : 1.0
// ============================================================================
module eth_tx_arb #(
    parameter int pIPG_CYCLES = 48,
    parameter int pTIMEOUT    = 4096
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Req,
    output logic [1:0] Gnt,
    output logic       Tx_Sel,
    output logic       Tx_Start,
    input  logic       Tx_Done,
    output logic       Tx_Abort,
    output logic       Busy
);
    localparam int                 c_GAP_W     = (pIPG_CYCLES > 1) ? $clog2(pIPG_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(pIPG_CYCLES - 1);
    localparam logic [15:0]        c_WDOG_LAST = 16'(pTIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_IPG    = 2'd2
    } state_t;

    logic               r_rstMeta_n;
    logic               r_rstSync_n;
    state_t             r_state;
    state_t             w_stateNxt;
    logic [1:0]         r_gnt;
    logic [1:0]         w_gntNxt;
    logic               r_txSel;
    logic               w_txSelNxt;
    logic               r_txStart;
    logic               w_txStartNxt;
    logic               r_txAbort;
    logic               w_txAbortNxt;
    logic               r_busy;
    logic               w_busyNxt;
    logic [15:0]        r_wdog;
    logic [15:0]        w_wdogNxt;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gapNxt;
    logic               r_last;
    logic               w_lastNxt;
    logic               w_pick;

    // Reset asserts immediately but releases only after two clean Clk edges.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rstMeta_n <= 1'b0;
            r_rstSync_n <= 1'b0;
        end else begin
            r_rstMeta_n <= 1'b1;
            r_rstSync_n <= r_rstMeta_n;
        end
    end

    always_ff @(posedge Clk or negedge r_rstSync_n) begin
        if (!r_rstSync_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 2'b00;
            r_txSel   <= 1'b0;
            r_txStart <= 1'b0;
            r_txAbort <= 1'b0;
            r_busy    <= 1'b0;
            r_wdog    <= 16'd0;
            r_gap     <= '0;
            r_last    <= 1'b1;
        end else begin
            r_state   <= w_stateNxt;
            r_gnt     <= w_gntNxt;
            r_txSel   <= w_txSelNxt;
            r_txStart <= w_txStartNxt;
            r_txAbort <= w_txAbortNxt;
            r_busy    <= w_busyNxt;
            r_wdog    <= w_wdogNxt;
            r_gap     <= w_gapNxt;
            r_last    <= w_lastNxt;
        end
    end

    // With both requesting, the one not served last time wins.
    assign w_pick = (Req == 2'b11) ? ~r_last : Req[1];

    always_comb begin
        w_stateNxt   = r_state;
        w_gntNxt     = r_gnt;
        w_txSelNxt   = r_txSel;
        w_txStartNxt = 1'b0;
        w_txAbortNxt = 1'b0;
        w_wdogNxt    = r_wdog;
        w_gapNxt     = r_gap;
        w_lastNxt    = r_last;
        case (r_state)
            ST_IDLE: begin
                if (Req != 2'b00) begin
                    w_stateNxt   = ST_ACTIVE;
                    w_gntNxt     = w_pick ? 2'b10 : 2'b01;
                    w_txSelNxt   = w_pick;
                    w_txStartNxt = 1'b1;
                    w_lastNxt    = w_pick;
                    w_wdogNxt    = 16'd0;
                end
            end
            ST_ACTIVE: begin
                if (Tx_Done) begin
                    w_stateNxt = ST_IPG;
                    w_gntNxt   = 2'b00;
                    w_gapNxt   = '0;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_stateNxt   = ST_IPG;
                    w_gntNxt     = 2'b00;
                    w_txAbortNxt = 1'b1;
                    w_gapNxt     = '0;
                end else begin
                    w_wdogNxt = r_wdog + 16'd1;
                end
            end
            ST_IPG: begin
                if (r_gap == c_GAP_LAST) begin
                    w_stateNxt = ST_IDLE;
                end else begin
                    w_gapNxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_stateNxt = ST_IDLE;
                w_gntNxt   = 2'b00;
                w_txSelNxt = 1'b0;
                w_wdogNxt  = 16'd0;
                w_gapNxt   = '0;
            end
        endcase
        w_busyNxt = (w_stateNxt != ST_IDLE);
    end

    assign Gnt      = r_gnt;
    assign Tx_Sel   = r_txSel;
    assign Tx_Start = r_txStart;
    assign Tx_Abort = r_txAbort;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arb
// Brief    : Randomized directed bench for eth_tx_arb against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_eth_tx_arb;
    logic       Clk     = 1'b0;
    logic       Rst_n   = 1'b0;
    logic [1:0] Req     = 2'b00;
    logic       Tx_Done = 1'b0;
    logic [1:0] Gnt;
    logic       Tx_Sel;
    logic       Tx_Start;
    logic       Tx_Abort;
    logic       Busy;

    int vectors     = 0;
    int miscompares = 0;
    bit mLast       = 1'b1;

    eth_tx_arb #(.pIPG_CYCLES(48), .pTIMEOUT(4096)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Req      (Req),
        .Gnt      (Gnt),
        .Tx_Sel   (Tx_Sel),
        .Tx_Start (Tx_Start),
        .Tx_Done  (Tx_Done),
        .Tx_Abort (Tx_Abort),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    logic [5:0] w_obs;
    logic [4:0] w_obsNoSel;
    assign w_obs      = {Gnt, Tx_Sel, Tx_Start, Tx_Abort, Busy};
    assign w_obsNoSel = {Gnt, Tx_Start, Tx_Abort, Busy};

    function automatic bit pick(input logic [1:0] r, input bit last);
        if (r == 2'b11) return !last;
        return r[1];
    endfunction

    function automatic logic [1:0] onehot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic grantCheck(input logic [1:0] r);
        bit w;
        w = pick(r, mLast);
        check("grant", 32'(w_obs), 32'({onehot(w), w, 1'b1, 1'b0, 1'b1}));
        mLast = w;
    endtask

    task automatic holdActive(input int n);
        for (int i = 0; i < n; i++) begin
            Req = 2'($urandom_range(0, 3));
            tick();
            check("hold", 32'(w_obs), 32'({onehot(mLast), mLast, 1'b0, 1'b0, 1'b1}));
        end
    endtask

    task automatic doneEnd();
        Tx_Done = 1'b1;
        tick();
        Tx_Done = 1'b0;
        check("done", 32'(w_obsNoSel), 32'(5'b00001));
    endtask

    task automatic gapToGrant(input logic [1:0] r);
        int zeros;
        zeros = 1;
        for (int i = 0; i < 200; i++) begin
            if (zeros < 40) begin
                Req     = 2'($urandom_range(0, 3));
                Tx_Done = 1'($urandom_range(0, 1));
            end else begin
                Req     = r;
                Tx_Done = 1'b0;
            end
            tick();
            if (Gnt != 2'b00) break;
            zeros++;
        end
        Tx_Done = 1'b0;
        check("gap_len", 32'(zeros), 32'd49);
        grantCheck(r);
    endtask

    task automatic gapToIdle(input int startCnt);
        int busyCnt;
        busyCnt = startCnt;
        Req     = 2'b00;
        for (int i = 0; i < 200; i++) begin
            Tx_Done = 1'($urandom_range(0, 1));
            tick();
            if (!Busy) break;
            busyCnt++;
        end
        Tx_Done = 1'b0;
        check("ipg_len", 32'(busyCnt), 32'd48);
        check("idle_out", 32'(w_obsNoSel), 32'd0);
    endtask

    initial begin
        logic [1:0] r;

        // Reset state and clean release
        tick();
        tick();
        check("in_reset", 32'(w_obs), 32'd0);
        #2 Rst_n = 1'b1;
        tick(); tick(); tick();
        check("post_reset", 32'(w_obs), 32'd0);

        Tx_Done = 1'b1;
        tick();
        Tx_Done = 1'b0;
        check("idle_done", 32'(w_obs), 32'd0);

        // Both requesting: 0 first, then alternate
        Req = 2'b11;
        tick();
        grantCheck(2'b11);
        tick();
        check("start_pulse", 32'(Tx_Start), 32'd0);
        holdActive(199);
        doneEnd();
        gapToGrant(2'b11);
        holdActive(int'($urandom_range(1, 50)));
        doneEnd();
        gapToGrant(2'b11);

        // Single requester 0 repeatedly
        for (int k = 0; k < 3; k++) begin
            holdActive(int'($urandom_range(0, 40)));
            doneEnd();
            gapToGrant(2'b01);
        end

        // Random request patterns
        for (int k = 0; k < 6; k++) begin
            r = 2'($urandom_range(1, 3));
            holdActive(int'($urandom_range(0, 60)));
            doneEnd();
            gapToGrant(r);
        end
        holdActive(int'($urandom_range(0, 10)));
        doneEnd();
        gapToIdle(1);

        // Watchdog expiry
        r   = 2'($urandom_range(1, 3));
        Req = r;
        tick();
        grantCheck(r);
        holdActive(4095);
        tick();
        check("abort", 32'(w_obsNoSel), 32'(5'b00011));
        Req = 2'b00;
        tick();
        check("abort_pulse", 32'(Tx_Abort), 32'd0);
        gapToIdle(2);

        // Tx_Done coincident with expiry
        r   = 2'($urandom_range(1, 3));
        Req = r;
        tick();
        grantCheck(r);
        holdActive(4095);
        doneEnd();
        gapToIdle(1);

        // Asynchronous reset mid-ACTIVE
        r   = 2'($urandom_range(1, 3));
        Req = r;
        tick();
        grantCheck(r);
        holdActive(5);
        #3 Rst_n = 1'b0;
        Req = 2'b00;
        #1;
        check("async_rst", 32'(w_obs), 32'd0);
        mLast = 1'b1;
        tick(); tick();
        check("rst_hold", 32'(w_obs), 32'd0);
        Rst_n = 1'b1;
        tick(); tick(); tick();
        check("rst_release", 32'(w_obs), 32'd0);
        Req = 2'b11;
        tick();
        grantCheck(2'b11);

        // Asynchronous reset mid-IPG
        holdActive(3);
        doneEnd();
        Req = 2'b00;
        tick(); tick();
        #3 Rst_n = 1'b0;
        #1;
        check("ipg_rst", 32'(w_obs), 32'd0);
        mLast = 1'b1;
        tick();
        Rst_n = 1'b1;
        tick(); tick(); tick();
        Req = 2'b10;
        tick();
        grantCheck(2'b10);
        holdActive(4);
        doneEnd();
        gapToIdle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
